// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store with lane merging and fixed wait states.
// Optional misaligned-access trapping is enabled with `define DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [63:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_sign_i,
    input  logic [63:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [3:0]        count, count_next;

    logic [63:0]       mem [DEPTH_WORDS];

    logic              accept;
    logic              store_en;
    logic              enter_resp;
    logic [IDX_W-1:0]  acc_idx;
    logic [2:0]        acc_lane;
    logic              acc_err;
    logic [63:0]       wmask;
    logic [63:0]       wshift;

    logic              lat_write;
    logic [1:0]        lat_size;
    logic              lat_sign;
    logic [2:0]        lat_lane;
    logic [IDX_W-1:0]  lat_idx;
    logic              lat_err;

    logic              rd_write;
    logic [1:0]        rd_size;
    logic              rd_sign;
    logic [2:0]        rd_lane;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_err;
    logic [63:0]       rd_shifted;
    logic [63:0]       load_data;

    logic [63:0]       rsp_rdata;
    logic              rsp_err;

    logic              addr_unused;

    function automatic logic [63:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [1:0] size, input logic sign,
                                           input logic [63:0] data);
        case (size)
            2'd0:    return sign ? {{56{data[7]}},  data[7:0]}  : {56'd0, data[7:0]};
            2'd1:    return sign ? {{48{data[15]}}, data[15:0]} : {48'd0, data[15:0]};
            2'd2:    return sign ? {{32{data[31]}}, data[31:0]} : {32'd0, data[31:0]};
            default: return data;
        endcase
    endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lane);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return lane[0];
            2'd2:    return lane[1:0] != 2'b00;
            default: return lane != 3'b000;
        endcase
    endfunction

    assign acc_lane = req_addr_i[2:0];
    assign acc_err  = misaligned(req_size_i, req_addr_i[2:0]);
`else
    function automatic logic [2:0] align_lane(input logic [1:0] size, input logic [2:0] lane);
        case (size)
            2'd0:    return lane;
            2'd1:    return {lane[2:1], 1'b0};
            2'd2:    return {lane[2], 2'b00};
            default: return 3'b000;
        endcase
    endfunction

    assign acc_lane = align_lane(req_size_i, req_addr_i[2:0]);
    assign acc_err  = 1'b0;
`endif

    // Address bits above the word index alias onto the array.
    assign addr_unused = ^req_addr_i[63:3+IDX_W];

    assign acc_idx  = req_addr_i[3 +: IDX_W];
    assign accept   = (state == S_IDLE) && req_valid_i;
    assign store_en = accept && req_write_i && !acc_err;
    assign wmask    = size_mask(req_size_i) << {acc_lane, 3'b000};
    assign wshift   = req_wdata_i << {acc_lane, 3'b000};

    always_ff @(posedge clk_i) begin
        if (store_en) begin
            mem[acc_idx] <= (mem[acc_idx] & ~wmask) | (wshift & wmask);
        end
    end

    // With zero wait states RESP is entered on the acceptance edge, so read from the live request.
    always_comb begin
        if (state == S_IDLE) begin
            rd_write = req_write_i;
            rd_size  = req_size_i;
            rd_sign  = req_sign_i;
            rd_lane  = acc_lane;
            rd_idx   = acc_idx;
            rd_err   = acc_err;
        end else begin
            rd_write = lat_write;
            rd_size  = lat_size;
            rd_sign  = lat_sign;
            rd_lane  = lat_lane;
            rd_idx   = lat_idx;
            rd_err   = lat_err;
        end
    end

    assign rd_shifted = mem[rd_idx] >> {rd_lane, 3'b000};
    assign load_data  = (rd_write || rd_err) ? '0 : extend(rd_size, rd_sign, rd_shifted);
    assign enter_resp = (state != S_RESP) && (state_next == S_RESP);

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (WAIT_STATES > 0) begin
                        state_next = S_WAIT;
                        count_next = WAIT_LOAD;
                    end else begin
                        state_next = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (count == 4'd0) begin
                    state_next = S_RESP;
                end else begin
                    count_next = count - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lat_write <= 1'b0;
            lat_size  <= '0;
            lat_sign  <= 1'b0;
            lat_lane  <= '0;
            lat_idx   <= '0;
            lat_err   <= 1'b0;
        end else if (accept) begin
            lat_write <= req_write_i;
            lat_size  <= req_size_i;
            lat_sign  <= req_sign_i;
            lat_lane  <= acc_lane;
            lat_idx   <= acc_idx;
            lat_err   <= acc_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            rsp_rdata <= load_data;
            rsp_err   <= rd_err;
        end
    end

    assign req_ready_o = (state == S_IDLE);
    assign rsp_valid_o = (state == S_RESP);
    assign rsp_rdata_o = rsp_rdata;
    assign rsp_err_o   = rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array memory model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned WS    = 1;
    localparam int unsigned BYTES = DEPTH * 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [63:0] req_addr_i;
    logic [1:0]  req_size_i;
    logic        req_sign_i;
    logic [63:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i),
        .req_size_i(req_size_i), .req_sign_i(req_sign_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem_b [BYTES];
    int          cyc = 0;
    int          checks = 0;
    int          passes = 0;
    bit          bp_arm = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    endtask

    // Reference behaviour: byte-addressed memory, access of 2**size bytes.
    function automatic void model(input logic w, input logic [63:0] a, input logic [1:0] s,
                                  input logic sg, input logic [63:0] wd,
                                  output logic [63:0] rd, output logic er);
        int unsigned nb   = 1 << s;
        int unsigned base = int'(a % 64'(BYTES));
        rd = '0;
        er = 1'b0;
        if (base % nb != 0) begin
`ifdef DMEM_MISALIGN_TRAP_EN
            er = 1'b1;
            return;
`else
            base = base - (base % nb);
`endif
        end
        if (w) begin
            for (int unsigned i = 0; i < nb; i++) mem_b[base + i] = wd[8*i +: 8];
        end else begin
            for (int unsigned i = 0; i < nb; i++) rd = rd | (64'(mem_b[base + i]) << (8*i));
            if (sg && nb < 8 && rd[8*nb-1]) rd = rd | (64'hFFFF_FFFF_FFFF_FFFF << (8*nb));
        end
    endfunction

    task automatic issue(input logic w, input logic [63:0] a, input logic [1:0] s,
                         input logic sg, input logic [63:0] wd);
        exp_t e;
        int   n = 0;
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_write_i = w;
        req_addr_i  = a;
        req_size_i  = s;
        req_sign_i  = sg;
        req_wdata_i = wd;
        while (!req_ready_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            check("accept_timeout", 64'(req_ready_o), 64'd1);
            req_valid_i = 1'b0;
            return;
        end
        model(w, a, s, sg, wd, e.rdata, e.err);
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
    endtask

    // Monitor: owns rsp_ready_i, checks latency, hold-stability and response contents.
    initial begin : monitor
        bit          in_resp   = 0;
        bit          idle_next = 0;
        int          bp_cnt    = 0;
        logic [63:0] held_d    = '0;
        logic        held_e    = 1'b0;
        exp_t        e;
        rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                in_resp   = 0;
                idle_next = 0;
                continue;
            end
            if (idle_next) begin
                check("idle_after_handshake", {62'd0, req_ready_o, rsp_valid_o}, 64'd2);
                idle_next = 0;
            end
            if (rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_response", 64'(rsp_valid_o), 64'd0);
                end else if (!in_resp) begin
                    in_resp = 1;
                    held_d  = rsp_rdata_o;
                    held_e  = rsp_err_o;
                    check("latency", 64'(cyc), 64'(exp_q[0].acc + int'(WS)));
                end else begin
                    check("hold_rdata", rsp_rdata_o, held_d);
                    check("hold_err", 64'(rsp_err_o), 64'(held_e));
                end
                check("req_ready_low_in_resp", 64'(req_ready_o), 64'd0);
            end
            if (bp_arm) begin
                if (rsp_valid_o && bp_cnt < 5) begin
                    rsp_ready_i = 1'b0;
                    bp_cnt++;
                end else if (rsp_valid_o) begin
                    rsp_ready_i = 1'b1;
                    bp_cnt = 0;
                    bp_arm = 0;
                end else begin
                    rsp_ready_i = 1'b0;
                end
            end else begin
                rsp_ready_i = ($urandom_range(0, 3) != 0);
            end
            if (rsp_valid_o && rsp_ready_i && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata_o, e.rdata);
                check("rsp_err", 64'(rsp_err_o), 64'(e.err));
                in_resp   = 0;
                idle_next = 1;
            end
        end
    end

    initial begin : stimulus
        int n;
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_size_i  = '0;
        req_sign_i  = 1'b0;
        req_wdata_i = '0;
        repeat (3) @(negedge clk_i);
        check("reset_req_ready", 64'(req_ready_o), 64'd1);
        check("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("reset_rsp_rdata", rsp_rdata_o, 64'd0);
        check("reset_rsp_err", 64'(rsp_err_o), 64'd0);
        #2 rst_i = 1'b1;

        for (int unsigned w = 0; w < DEPTH; w++)
            issue(1'b1, 64'(w * 8), 2'd3, 1'b0, {$urandom, $urandom});

        issue(1'b1, 64'h40, 2'd3, 1'b0, 64'h1122_3344_5566_7788);
        issue(1'b0, 64'h40, 2'd3, 1'b0, '0);
        issue(1'b1, 64'h43, 2'd0, 1'b0, 64'h0000_0000_0000_00AA);
        issue(1'b0, 64'h40, 2'd2, 1'b1, '0);
        issue(1'b0, 64'h44, 2'd2, 1'b0, '0);
        issue(1'b0, 64'h43, 2'd0, 1'b1, '0);
        issue(1'b0, 64'h43, 2'd0, 1'b0, '0);
        issue(1'b0, 64'h46, 2'd1, 1'b1, '0);

        bp_arm = 1;
        issue(1'b0, 64'h40, 2'd3, 1'b0, '0);
        n = 0;
        while (bp_arm && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        check("backpressure_done", 64'(bp_arm), 64'd0);

        issue(1'b1, 64'h42, 2'd2, 1'b0, 64'h0000_0000_DEAD_BEEF);
        issue(1'b0, 64'h40, 2'd3, 1'b0, '0);

        // Reset while the store's response is pending in WAIT.
        issue(1'b1, 64'h80, 2'd3, 1'b0, 64'hCAFE_F00D_1234_5678);
        @(negedge clk_i);
        check("in_wait_state", {62'd0, req_ready_o, rsp_valid_o}, 64'd0);
        #2 rst_i = 1'b0;
        #1;
        check("async_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("async_rst_req_ready", 64'(req_ready_o), 64'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            check("no_rsp_after_reset", 64'(rsp_valid_o), 64'd0);
        end
        issue(1'b0, 64'h80, 2'd3, 1'b0, '0);

        for (int i = 0; i < 300; i++) begin
            logic [63:0] a;
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) a = 64'($urandom_range(0, BYTES - 1));
            issue(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), {$urandom, $urandom});
        end

        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_scoreboard", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk_i);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
